// File: rtl/time_setter.sv
// rtl/time_setter.sv - set-time editor FSM driving the clock counter run/load/hold port
// Edge-detects the four buttons, edits a BCD HH:MM:SS copy and issues a one-cycle load.
module time_setter (
  input  logic        clk_1hz,
  input  logic        rst,
  input  logic        btn_set,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] time_now,
  output logic [23:0] time_set,
  output logic [1:0]  clk_mode,
  output logic [1:0]  field_sel,
  output logic        blink
);

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_EDIT_HR  = 3'd1;
  localparam logic [2:0] ST_EDIT_MIN = 3'd2;
  localparam logic [2:0] ST_EDIT_SEC = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;

  // Last idle count before the timeout edge: the 30th press-free cycle returns to RUN.
  localparam logic [4:0] IDLE_LAST = 5'd29;

  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] MS_MAX  = 8'h59;

  logic [2:0] state, state_nxt;
  logic [4:0] idle_cnt, idle_nxt;
  logic       blink_nxt;
  logic [7:0] hr, mn, sc;
  logic [7:0] hr_nxt, mn_nxt, sc_nxt;
  logic       set_q, next_q, inc_q, dec_q;
  logic       set_p, next_p, inc_p, dec_p, any_p;
  logic       in_edit;

  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max)
      return 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)
      return max;
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign set_p  = btn_set  & ~set_q;
  assign next_p = btn_next & ~next_q;
  assign inc_p  = btn_inc  & ~inc_q;
  assign dec_p  = btn_dec  & ~dec_q;
  assign any_p  = set_p | next_p | inc_p | dec_p;

  assign in_edit = (state == ST_EDIT_HR) || (state == ST_EDIT_MIN) || (state == ST_EDIT_SEC);

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    blink_nxt = 1'b0;
    hr_nxt    = hr;
    mn_nxt    = mn;
    sc_nxt    = sc;
    case (state)
      ST_RUN: begin
        if (set_p) begin
          hr_nxt    = bcd_sanitize(time_now[23:16], HR_MAX);
          mn_nxt    = bcd_sanitize(time_now[15:8],  MS_MAX);
          sc_nxt    = bcd_sanitize(time_now[7:0],   MS_MAX);
          state_nxt = ST_EDIT_HR;
          idle_nxt  = 5'd0;
          blink_nxt = 1'b1;
        end
      end
      ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC: begin
        blink_nxt = ~blink;
        idle_nxt  = any_p ? 5'd0 : idle_cnt + 5'd1;
        if (set_p) begin
          state_nxt = ST_RUN;
        end else if (next_p) begin
          case (state)
            ST_EDIT_HR:  state_nxt = ST_EDIT_MIN;
            ST_EDIT_MIN: state_nxt = ST_EDIT_SEC;
            default:     state_nxt = ST_LOAD;
          endcase
        end else if (inc_p ^ dec_p) begin
          case (state)
            ST_EDIT_HR:  hr_nxt = inc_p ? bcd_inc(hr, HR_MAX) : bcd_dec(hr, HR_MAX);
            ST_EDIT_MIN: mn_nxt = inc_p ? bcd_inc(mn, MS_MAX) : bcd_dec(mn, MS_MAX);
            default:     sc_nxt = inc_p ? bcd_inc(sc, MS_MAX) : bcd_dec(sc, MS_MAX);
          endcase
        end else if (!any_p && idle_cnt == IDLE_LAST) begin
          state_nxt = ST_RUN;
        end
        if (state_nxt == ST_RUN || state_nxt == ST_LOAD) begin
          blink_nxt = 1'b0;
          idle_nxt  = 5'd0;
        end
      end
      ST_LOAD: state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      idle_cnt <= 5'd0;
      blink    <= 1'b0;
      hr       <= 8'h00;
      mn       <= 8'h00;
      sc       <= 8'h00;
      set_q    <= 1'b0;
      next_q   <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      blink    <= blink_nxt;
      hr       <= hr_nxt;
      mn       <= mn_nxt;
      sc       <= sc_nxt;
      set_q    <= btn_set;
      next_q   <= btn_next;
      inc_q    <= btn_inc;
      dec_q    <= btn_dec;
    end
  end

  assign time_set = {hr, mn, sc};

  always_comb begin
    clk_mode  = 2'b00;
    field_sel = 2'b00;
    if (in_edit) begin
      clk_mode  = 2'b10;
      field_sel = state[1:0];
    end else if (state == ST_LOAD) begin
      clk_mode = 2'b01;
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// tb/tb_time_setter.sv - directed vectors, corner sequences and randomized model check for time_setter
module tb_time_setter;

  logic        clk_1hz;
  logic        rst;
  logic        btn_set, btn_next, btn_inc, btn_dec;
  logic [23:0] time_now;
  logic [23:0] time_set;
  logic [1:0]  clk_mode;
  logic [1:0]  field_sel;
  logic        blink;

  int n_pass  = 0;
  int n_total = 0;

  time_setter dut (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .btn_set  (btn_set),
    .btn_next (btn_next),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .time_now (time_now),
    .time_set (time_set),
    .clk_mode (clk_mode),
    .field_sel(field_sel),
    .blink    (blink)
  );

  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  typedef struct {
    logic        s, n, i, d;
    logic [23:0] tn;
    logic [23:0] ts;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic        bl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic drive(input logic s, input logic n, input logic i, input logic d);
    btn_set = s; btn_next = n; btn_inc = i; btn_dec = d;
  endtask

  task automatic add_vec(input logic s, input logic n, input logic i, input logic d,
                         input logic [23:0] tn, input logic [23:0] ts,
                         input logic [1:0] mode, input logic [1:0] sel, input logic bl);
    vec_t v;
    v.s = s; v.n = n; v.i = i; v.d = d; v.tn = tn;
    v.ts = ts; v.mode = mode; v.sel = sel; v.bl = bl;
    vecs.push_back(v);
  endtask

  // Reference model: ph 0 = run, 1..3 = editing hour/minute/second, 4 = load.
  int m_ph, m_h, m_m, m_s, m_idle;
  bit m_blink, p_s, p_n, p_i, p_d;

  function automatic int bcd2int(input logic [7:0] b, input int mx);
    int hi, lo, v;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9 || lo > 9) return 0;
    v = hi * 10 + lo;
    return (v > mx) ? 0 : v;
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r = 8'((v / 10) * 16 + (v % 10));
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_blink = 0;
    p_s = 0; p_n = 0; p_i = 0; p_d = 0;
  endtask

  task automatic model_step(input bit s, input bit n, input bit i, input bit d, input logic [23:0] tn);
    bit ps, pn, pi, pd, any;
    int mx, v;
    ps = s && !p_s; pn = n && !p_n; pi = i && !p_i; pd = d && !p_d;
    any = ps || pn || pi || pd;
    p_s = s; p_n = n; p_i = i; p_d = d;
    if (m_ph == 4) begin
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (ps) begin
        m_h = bcd2int(tn[23:16], 23);
        m_m = bcd2int(tn[15:8], 59);
        m_s = bcd2int(tn[7:0], 59);
        m_ph = 1; m_idle = 0; m_blink = 1;
      end
    end else begin
      if (ps) m_ph = 0;
      else if (pn) m_ph = m_ph + 1;
      else if (pi != pd) begin
        mx = (m_ph == 1) ? 23 : 59;
        v  = (m_ph == 1) ? m_h : (m_ph == 2) ? m_m : m_s;
        v  = pi ? (v + 1) % (mx + 1) : (v + mx) % (mx + 1);
        if (m_ph == 1) m_h = v; else if (m_ph == 2) m_m = v; else m_s = v;
      end
      m_idle = any ? 0 : m_idle + 1;
      if (m_idle == 30) m_ph = 0;
      if (m_ph >= 1 && m_ph <= 3) m_blink = !m_blink;
      else begin m_blink = 0; m_idle = 0; end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    time_now = 24'h0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_outs(input string tag, input logic [23:0] ts, input logic [1:0] mode,
                            input logic [1:0] sel, input logic bl);
    check({tag, ".time_set"},  time_set,          ts);
    check({tag, ".clk_mode"},  {22'd0, clk_mode}, {22'd0, mode});
    check({tag, ".field_sel"}, {22'd0, field_sel},{22'd0, sel});
    check({tag, ".blink"},     {23'd0, blink},    {23'd0, bl});
  endtask

  initial begin
    bit saw_load;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    time_now = 24'h0;
    #2;
    check_outs("reset", 24'h000000, 2'b00, 2'b00, 1'b0);
    tick();
    rst = 1'b0;

    // set/next x3 commit, BCD wrap/carry/borrow, abort, invalid capture, held inc, inc+dec
    add_vec(1,0,0,0, 24'h123456, 24'h123456, 2'b10, 2'b01, 1);
    add_vec(0,1,0,0, 24'h0,      24'h123456, 2'b10, 2'b10, 0);
    add_vec(0,0,0,0, 24'h0,      24'h123456, 2'b10, 2'b10, 1);
    add_vec(0,1,0,0, 24'h0,      24'h123456, 2'b10, 2'b11, 0);
    add_vec(0,0,0,0, 24'h0,      24'h123456, 2'b10, 2'b11, 1);
    add_vec(0,1,0,0, 24'h0,      24'h123456, 2'b01, 2'b00, 0);
    add_vec(0,0,0,0, 24'h0,      24'h123456, 2'b00, 2'b00, 0);
    add_vec(1,0,0,0, 24'h230910, 24'h230910, 2'b10, 2'b01, 1);
    add_vec(0,0,1,0, 24'h0,      24'h000910, 2'b10, 2'b01, 0);
    add_vec(0,1,0,0, 24'h0,      24'h000910, 2'b10, 2'b10, 1);
    add_vec(0,0,1,0, 24'h0,      24'h001010, 2'b10, 2'b10, 0);
    add_vec(0,1,0,0, 24'h0,      24'h001010, 2'b10, 2'b11, 1);
    add_vec(0,0,0,1, 24'h0,      24'h001009, 2'b10, 2'b11, 0);
    add_vec(1,0,0,0, 24'h0,      24'h001009, 2'b00, 2'b00, 0);
    add_vec(0,0,0,0, 24'h0,      24'h001009, 2'b00, 2'b00, 0);
    add_vec(1,0,0,0, 24'h000010, 24'h000010, 2'b10, 2'b01, 1);
    add_vec(0,1,0,0, 24'h0,      24'h000010, 2'b10, 2'b10, 0);
    add_vec(0,0,0,1, 24'h0,      24'h005910, 2'b10, 2'b10, 1);
    add_vec(0,1,0,0, 24'h0,      24'h005910, 2'b10, 2'b11, 0);
    add_vec(0,0,0,1, 24'h0,      24'h005909, 2'b10, 2'b11, 1);
    add_vec(1,0,0,0, 24'h0,      24'h005909, 2'b00, 2'b00, 0);
    add_vec(0,0,0,0, 24'h0,      24'h005909, 2'b00, 2'b00, 0);
    add_vec(1,0,0,0, 24'h7A6105, 24'h000005, 2'b10, 2'b01, 1);
    add_vec(0,0,1,0, 24'h0,      24'h010005, 2'b10, 2'b01, 0);
    add_vec(0,0,1,0, 24'h0,      24'h010005, 2'b10, 2'b01, 1);
    add_vec(0,0,1,0, 24'h0,      24'h010005, 2'b10, 2'b01, 0);
    add_vec(0,0,1,0, 24'h0,      24'h010005, 2'b10, 2'b01, 1);
    add_vec(0,0,1,0, 24'h0,      24'h010005, 2'b10, 2'b01, 0);
    add_vec(0,0,0,0, 24'h0,      24'h010005, 2'b10, 2'b01, 1);
    add_vec(0,0,1,1, 24'h0,      24'h010005, 2'b10, 2'b01, 0);
    add_vec(0,0,0,0, 24'h0,      24'h010005, 2'b10, 2'b01, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].s, vecs[k].n, vecs[k].i, vecs[k].d);
      time_now = vecs[k].tn;
      tick();
      check_outs($sformatf("vec%0d", k), vecs[k].ts, vecs[k].mode, vecs[k].sel, vecs[k].bl);
    end

    // Inactivity timeout: leave edit, re-enter, 29 idle cycles stay, 30th returns to RUN.
    drive(1,0,0,0); tick();
    drive(0,0,0,0); tick();
    drive(1,0,0,0); tick();
    drive(0,0,0,0);
    saw_load = 0;
    for (int k = 0; k < 29; k++) begin tick(); if (clk_mode == 2'b01) saw_load = 1; end
    check("idle29.field_sel", {22'd0, field_sel}, 24'd1);
    tick();
    if (clk_mode == 2'b01) saw_load = 1;
    check("idle30.field_sel", {22'd0, field_sel}, 24'd0);
    check("idle30.clk_mode",  {22'd0, clk_mode},  24'd0);
    check("idle.no_load", {23'd0, saw_load}, 24'd0);

    // A press on the 29th idle cycle restarts the count.
    drive(1,0,0,0); tick();
    drive(0,0,0,0);
    for (int k = 0; k < 28; k++) tick();
    drive(0,0,1,0); tick();
    drive(0,0,0,0);
    for (int k = 0; k < 29; k++) tick();
    check("restart29.field_sel", {22'd0, field_sel}, 24'd1);
    tick();
    check("restart30.field_sel", {22'd0, field_sel}, 24'd0);

    // Abort from EDIT_MIN never loads.
    drive(1,0,0,0); tick();
    drive(0,1,0,0); tick();
    check("abort.in_min", {22'd0, field_sel}, 24'd2);
    drive(1,0,0,0); tick();
    check("abort.mode0", {22'd0, clk_mode}, 24'd0);
    drive(0,0,0,0); tick();
    check("abort.mode1", {22'd0, clk_mode}, 24'd0);

    // Asynchronous reset during EDIT_SEC, then set held through release counts once.
    time_now = 24'h112233;
    drive(1,0,0,0); tick();
    drive(0,1,0,0); tick();
    drive(0,0,0,0); tick();
    drive(0,1,0,0); tick();
    check("pre_rst.field_sel", {22'd0, field_sel}, 24'd3);
    drive(1,0,0,0);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 24'h000000, 2'b00, 2'b00, 1'b0);
    tick();
    rst = 1'b0;
    check("rst_release.field_sel", {22'd0, field_sel}, 24'd0);
    tick();
    check_outs("held_set", 24'h112233, 2'b10, 2'b01, 1'b1);
    drive(0,0,0,0); tick();

    // Randomized run against the reference model.
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      bit s, n, i, d;
      logic [23:0] tn;
      if ((k % 120) > 70) begin
        s = 0; n = 0; i = 0; d = 0;
      end else begin
        s = ($urandom_range(0, 5) == 0);
        n = ($urandom_range(0, 3) == 0);
        i = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 2) == 0) tn = 24'($urandom);
      else tn = {int2bcd($urandom_range(0, 23)), int2bcd($urandom_range(0, 59)),
                 int2bcd($urandom_range(0, 59))};
      drive(s, n, i, d);
      time_now = tn;
      tick();
      model_step(s, n, i, d, tn);
      check_outs($sformatf("rnd%0d", k), {int2bcd(m_h), int2bcd(m_m), int2bcd(m_s)},
                 (m_ph == 4) ? 2'b01 : (m_ph != 0) ? 2'b10 : 2'b00,
                 (m_ph >= 1 && m_ph <= 3) ? 2'(m_ph) : 2'b00, m_blink);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
